// File: rtl/aqed_db_harness_ctrl.sv
// aqed_db_harness_ctrl: batch-gating A-QED harness controller with sticky bound and QED failure tracking
module aqed_db_harness_ctrl #(
    parameter int CNT_W       = 16,
    parameter int RD_MULT     = 4,
    parameter int BOUND_SLACK = 0,
    parameter int PC_W        = CNT_W + $clog2(RD_MULT) + 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clk_en,
    input  logic                            cfg_valid,
    input  logic [CNT_W-1:0]                cfg_depth,
    input  logic                            wen_req,
    input  logic                            ren_req,
    output logic                            wen,
    output logic                            ren,
    input  logic                            orig_issued,
    input  logic                            orig_done,
    input  logic                            qed_done,
    input  logic                            qed_check,
    output logic [CNT_W-1:0]                wr_cnt,
    output logic [CNT_W+$clog2(RD_MULT):0]  rd_cnt,
    output logic                            batch_done,
    output logic [2:0]                      state,
    output logic                            bound_fail,
    output logic                            qed_fail,
    output logic                            cfg_err
);
    localparam int RW = CNT_W + $clog2(RD_MULT) + 1;
    localparam int SH = $clog2(RD_MULT);

    typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, TRACK = 3'd2, DONE = 3'd3, FAIL = 3'd4} st_t;

    st_t              st_q, st_d;
    logic [CNT_W-1:0] depth_q, wr_nx;
    logic [RW-1:0]    rd_lim, rd_nx;
    logic [PC_W-1:0]  post_wr, post_rd;
    logic             active, batch_end, counting, qed_trip, bound_hit, cfg_bad;

    // RD_MULT is a power of two, so the read limit is a widening shift
    assign rd_lim    = RW'(depth_q) << SH;
    assign active    = (st_q == RUN) | (st_q == TRACK) | (st_q == DONE);
    assign wen       = wen_req & clk_en & active & (wr_cnt < depth_q);
    assign ren       = ren_req & clk_en & active & (rd_cnt < rd_lim);
    assign wr_nx     = wr_cnt + CNT_W'(wen);
    assign rd_nx     = rd_cnt + RW'(ren);
    assign batch_end = active & (wr_nx == depth_q) & (rd_nx == rd_lim);
    assign counting  = (st_q == TRACK) | ((st_q == RUN) & orig_issued);
    assign qed_trip  = qed_done & ~qed_check & (st_q != IDLE);
    assign bound_hit = (st_q == TRACK) & ~orig_done & (post_wr >= PC_W'(depth_q))
                     & (post_rd >= PC_W'(rd_lim) + PC_W'(BOUND_SLACK));
    assign cfg_bad   = cfg_valid & ((st_q != IDLE) | (cfg_depth == '0));
    assign state     = st_q;

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    st_d = (cfg_valid && cfg_depth != '0) ? RUN : IDLE;
            RUN:     st_d = orig_issued ? TRACK : RUN;
            TRACK:   st_d = orig_done ? DONE : bound_hit ? FAIL : TRACK;
            default: st_d = st_q;
        endcase
        if (qed_trip) st_d = FAIL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q       <= IDLE;
            depth_q    <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            post_wr    <= '0;
            post_rd    <= '0;
            batch_done <= 1'b0;
            bound_fail <= 1'b0;
            qed_fail   <= 1'b0;
            cfg_err    <= 1'b0;
        end else if (clk_en) begin
            st_q       <= st_d;
            if (st_q == IDLE && cfg_valid && cfg_depth != '0) depth_q <= cfg_depth;
            wr_cnt     <= batch_end ? '0 : wr_nx;
            rd_cnt     <= batch_end ? '0 : rd_nx;
            batch_done <= batch_end;
            if (counting && wen && post_wr != '1) post_wr <= post_wr + PC_W'(1);
            if (counting && ren && post_rd != '1) post_rd <= post_rd + PC_W'(1);
            if (bound_hit) bound_fail <= 1'b1;
            if (qed_trip) qed_fail <= 1'b1;
            if (cfg_bad) cfg_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aqed_db_harness_ctrl.sv
// tb_aqed_db_harness_ctrl: directed scenario tests for the A-QED batch harness controller
module tb_aqed_db_harness_ctrl;
    logic        clk = 1'b0, reset = 1'b0, clk_en = 1'b1;
    logic        cfg_valid = 1'b0, wen_req = 1'b0, ren_req = 1'b0;
    logic        orig_issued = 1'b0, orig_done = 1'b0, qed_done = 1'b0, qed_check = 1'b0;
    logic [15:0] cfg_depth = '0;
    logic        wen, ren, batch_done, bound_fail, qed_fail, cfg_err;
    logic [15:0] wr_cnt;
    logic [18:0] rd_cnt;
    logic [2:0]  state;
    int          errs = 0, checks = 0;

    aqed_db_harness_ctrl dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .cfg_valid(cfg_valid), .cfg_depth(cfg_depth),
        .wen_req(wen_req), .ren_req(ren_req), .wen(wen), .ren(ren),
        .orig_issued(orig_issued), .orig_done(orig_done), .qed_done(qed_done), .qed_check(qed_check),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .batch_done(batch_done), .state(state),
        .bound_fail(bound_fail), .qed_fail(qed_fail), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task step;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        reset = 1'b0; clk_en = 1'b1; cfg_valid = 1'b0; cfg_depth = '0;
        wen_req = 1'b0; ren_req = 1'b0; orig_issued = 1'b0; orig_done = 1'b0;
        qed_done = 1'b0; qed_check = 1'b0;
        step; step;
        reset = 1'b1;
        step;
    endtask

    task cfg(input int d);
        cfg_valid = 1'b1; cfg_depth = 16'(d);
        step;
        cfg_valid = 1'b0;
    endtask

    task test_reset;
        do_reset;
        #1;
        checks++; if (state !== 3'd0) begin errs++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (wr_cnt !== 16'd0 || rd_cnt !== 19'd0) begin errs++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", wr_cnt, rd_cnt); end
        checks++; if ({wen, ren, batch_done, bound_fail, qed_fail, cfg_err} !== 6'b0) begin errs++; $display("FAIL reset_flags got=%b exp=000000", {wen, ren, batch_done, bound_fail, qed_fail, cfg_err}); end
    endtask

    task test_full_batch;
        int nw, nr, nb;
        do_reset;
        cfg(3);
        checks++; if (state !== 3'd1) begin errs++; $display("FAIL fb_run state=%0d exp=1", state); end
        wen_req = 1'b1; ren_req = 1'b1; nw = 0; nr = 0; nb = 0;
        for (int i = 0; i < 12; i++) begin
            #1; nw += int'(wen); nr += int'(ren); nb += int'(batch_done);
            step;
        end
        checks++; if (nw != 3 || nr != 12) begin errs++; $display("FAIL fb_counts got=%0d/%0d exp=3/12", nw, nr); end
        checks++; if (nb != 0 || batch_done !== 1'b1) begin errs++; $display("FAIL fb_done early=%0d now=%b exp=0/1", nb, batch_done); end
        checks++; if (wr_cnt !== 16'd0 || rd_cnt !== 19'd0) begin errs++; $display("FAIL fb_clear got=%0d/%0d exp=0/0", wr_cnt, rd_cnt); end
        #1;
        checks++; if (wen !== 1'b1) begin errs++; $display("FAIL fb_next_wen got=%b exp=1", wen); end
        step;
        checks++; if (batch_done !== 1'b0 || wr_cnt !== 16'd1 || rd_cnt !== 19'd1) begin errs++; $display("FAIL fb_next got=%b/%0d/%0d exp=0/1/1", batch_done, wr_cnt, rd_cnt); end
        wen_req = 1'b0; ren_req = 1'b0;
    endtask

    task test_write_block;
        int nw, nr;
        do_reset;
        cfg(2);
        wen_req = 1'b1; nw = 0;
        for (int i = 0; i < 5; i++) begin #1; nw += int'(wen); step; end
        checks++; if (nw != 2 || wr_cnt !== 16'd2 || rd_cnt !== 19'd0) begin errs++; $display("FAIL wb_writes got=%0d/%0d/%0d exp=2/2/0", nw, wr_cnt, rd_cnt); end
        ren_req = 1'b1; nw = 0; nr = 0;
        for (int i = 0; i < 7; i++) begin #1; nw += int'(wen); nr += int'(ren); step; end
        checks++; if (nw != 0 || nr != 7 || rd_cnt !== 19'd7 || batch_done !== 1'b0) begin errs++; $display("FAIL wb_hold got=%0d/%0d/%0d/%b exp=0/7/7/0", nw, nr, rd_cnt, batch_done); end
        wen_req = 1'b0;
        step;
        checks++; if (batch_done !== 1'b1 || wr_cnt !== 16'd0 || rd_cnt !== 19'd0) begin errs++; $display("FAIL wb_done got=%b/%0d/%0d exp=1/0/0", batch_done, wr_cnt, rd_cnt); end
        wen_req = 1'b1; ren_req = 1'b0;
        step;
        wen_req = 1'b0; ren_req = 1'b1;
        repeat (7) step;
        checks++; if (batch_done !== 1'b0 || wr_cnt !== 16'd1 || rd_cnt !== 19'd7) begin errs++; $display("FAIL wb_pre got=%b/%0d/%0d exp=0/1/7", batch_done, wr_cnt, rd_cnt); end
        wen_req = 1'b1;
        #1;
        checks++; if (wen !== 1'b1 || ren !== 1'b1) begin errs++; $display("FAIL wb_both got=%b%b exp=11", wen, ren); end
        step;
        checks++; if (batch_done !== 1'b1 || wr_cnt !== 16'd0 || rd_cnt !== 19'd0) begin errs++; $display("FAIL wb_same got=%b/%0d/%0d exp=1/0/0", batch_done, wr_cnt, rd_cnt); end
        wen_req = 1'b0; ren_req = 1'b0;
        step;
        checks++; if (batch_done !== 1'b0 || wr_cnt !== 16'd0) begin errs++; $display("FAIL wb_pulse got=%b/%0d exp=0/0", batch_done, wr_cnt); end
    endtask

    task test_bound;
        do_reset;
        cfg(3);
        orig_issued = 1'b1; wen_req = 1'b1; ren_req = 1'b1;
        repeat (12) step;
        checks++; if (state !== 3'd2 || bound_fail !== 1'b0) begin errs++; $display("FAIL bd_pre got=%0d/%b exp=2/0", state, bound_fail); end
        step;
        checks++; if (bound_fail !== 1'b1 || state !== 3'd4) begin errs++; $display("FAIL bd_fail got=%b/%0d exp=1/4", bound_fail, state); end
        #1;
        checks++; if (wen !== 1'b0 || ren !== 1'b0) begin errs++; $display("FAIL bd_gate got=%b%b exp=00", wen, ren); end
        step;
        checks++; if (bound_fail !== 1'b1 || state !== 3'd4) begin errs++; $display("FAIL bd_sticky got=%b/%0d exp=1/4", bound_fail, state); end
        orig_issued = 1'b0; wen_req = 1'b0; ren_req = 1'b0;
    endtask

    task test_orig_done_wins;
        do_reset;
        cfg(3);
        orig_issued = 1'b1; wen_req = 1'b1; ren_req = 1'b1;
        repeat (11) step;
        orig_done = 1'b1;
        #1;
        checks++; if (ren !== 1'b1 || rd_cnt !== 19'd11) begin errs++; $display("FAIL od_last got=%b/%0d exp=1/11", ren, rd_cnt); end
        step;
        orig_done = 1'b0;
        checks++; if (state !== 3'd3 || bound_fail !== 1'b0) begin errs++; $display("FAIL od_done got=%0d/%b exp=3/0", state, bound_fail); end
        #1;
        checks++; if (wen !== 1'b1) begin errs++; $display("FAIL od_traffic got=%b exp=1", wen); end
        repeat (3) step;
        checks++; if (bound_fail !== 1'b0 || state !== 3'd3 || wr_cnt !== 16'd3) begin errs++; $display("FAIL od_cont got=%b/%0d/%0d exp=0/3/3", bound_fail, state, wr_cnt); end
        orig_issued = 1'b0; wen_req = 1'b0; ren_req = 1'b0;
    endtask

    task test_qed;
        qed_done = 1'b1; qed_check = 1'b1;
        step;
        checks++; if (qed_fail !== 1'b0 || state !== 3'd3) begin errs++; $display("FAIL qd_match got=%b/%0d exp=0/3", qed_fail, state); end
        qed_check = 1'b0;
        step;
        qed_done = 1'b0;
        checks++; if (qed_fail !== 1'b1 || state !== 3'd4) begin errs++; $display("FAIL qd_mismatch got=%b/%0d exp=1/4", qed_fail, state); end
        do_reset;
        qed_done = 1'b1; qed_check = 1'b0;
        step;
        qed_done = 1'b0;
        checks++; if (qed_fail !== 1'b0 || state !== 3'd0) begin errs++; $display("FAIL qd_idle got=%b/%0d exp=0/0", qed_fail, state); end
    endtask

    task test_cfg;
        int nw;
        do_reset;
        cfg(0);
        checks++; if (cfg_err !== 1'b1 || state !== 3'd0) begin errs++; $display("FAIL cf_zero got=%b/%0d exp=1/0", cfg_err, state); end
        wen_req = 1'b1;
        #1;
        checks++; if (wen !== 1'b0) begin errs++; $display("FAIL cf_idle_wen got=%b exp=0", wen); end
        wen_req = 1'b0;
        do_reset;
        cfg(2);
        checks++; if (cfg_err !== 1'b0 || state !== 3'd1) begin errs++; $display("FAIL cf_ok got=%b/%0d exp=0/1", cfg_err, state); end
        clk_en = 1'b0; wen_req = 1'b1;
        #1;
        checks++; if (wen !== 1'b0) begin errs++; $display("FAIL cf_clken_wen got=%b exp=0", wen); end
        step;
        checks++; if (wr_cnt !== 16'd0) begin errs++; $display("FAIL cf_clken_hold got=%0d exp=0", wr_cnt); end
        clk_en = 1'b1; wen_req = 1'b0;
        cfg(5);
        checks++; if (cfg_err !== 1'b1 || state !== 3'd1) begin errs++; $display("FAIL cf_run got=%b/%0d exp=1/1", cfg_err, state); end
        wen_req = 1'b1; ren_req = 1'b1; nw = 0;
        for (int i = 0; i < 4; i++) begin #1; nw += int'(wen); step; end
        checks++; if (nw != 2 || wr_cnt !== 16'd2 || rd_cnt !== 19'd4) begin errs++; $display("FAIL cf_depth got=%0d/%0d/%0d exp=2/2/4", nw, wr_cnt, rd_cnt); end
        reset = 1'b0;
        #1;
        checks++; if (wr_cnt !== 16'd0 || rd_cnt !== 19'd0 || state !== 3'd0) begin errs++; $display("FAIL cf_rst_cnt got=%0d/%0d/%0d exp=0/0/0", wr_cnt, rd_cnt, state); end
        checks++; if ({wen, ren, batch_done, bound_fail, qed_fail, cfg_err} !== 6'b0) begin errs++; $display("FAIL cf_rst_flags got=%b exp=000000", {wen, ren, batch_done, bound_fail, qed_fail, cfg_err}); end
        wen_req = 1'b0; ren_req = 1'b0;
    endtask

    initial begin
        test_reset;
        test_full_batch;
        test_write_block;
        test_bound;
        test_orig_done_wins;
        test_qed;
        test_cfg;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/aqed_db_harness_ctrl.md
Name: aqed_db_harness_ctrl

Overview:
Parametrised A-QED harness controller placed between the BMC-driven input stream and a double-buffer memory core run under the aqed_top wrapper.
- Gates write and read requests to whole batches of a latched depth, so batch limits are enforced in RTL rather than by input assumptions.
- Generalises the read multiplicity per batch and the response-bound slack.
- Tracks the original transaction to completion and latches sticky response-bound and QED-mismatch failures for formal or simulation checking.

Parameters:
CNT_W, 16, width of depth and batch counters
RD_MULT, 4, reads per batch = RD_MULT*depth (power of two, >=1)
BOUND_SLACK, 0, extra reads tolerated past RD_MULT*depth before bound failure
PC_W, CNT_W+$clog2(RD_MULT)+2, width of post-original counters (saturating)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
clk_en  in  1  qualifies every state and counter update
cfg_valid  in  1  one-cycle strobe: latch cfg_depth
cfg_depth  in  CNT_W  batch depth in writes
wen_req  in  1  BMC write request
ren_req  in  1  BMC read request
wen  out  1  gated write enable to core
ren  out  1  gated read enable to core
orig_issued  in  1  aqed: original transaction issued (level)
orig_done  in  1  aqed: original output returned (pulse)
qed_done  in  1  aqed: duplicate comparison complete
qed_check  in  1  aqed: comparison result (1 = match)
wr_cnt  out  CNT_W  writes accepted in current batch
rd_cnt  out  CNT_W+$clog2(RD_MULT)+1  reads accepted in current batch
batch_done  out  1  one-cycle pulse at batch completion
state  out  3  FSM state encoding
bound_fail  out  1  sticky response-bound violation
qed_fail  out  1  sticky QED mismatch
cfg_err  out  1  sticky illegal configuration

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all counters 0; depth_q=0.
  - wen, ren, batch_done, bound_fail, qed_fail and cfg_err are all 0.
  - A reset mid-batch discards the batch. No output glitches on release.
- Register updates occur only when clk_en=1. wen and ren are combinational and forced to 0 when clk_en=0.
- FSM states:
  - IDLE=0: cfg_valid with cfg_depth>0 latches depth_q and goes to RUN. cfg_valid with cfg_depth==0 sets cfg_err and stays in IDLE.
  - RUN=1: orig_issued=1 goes to TRACK.
  - TRACK=2: orig_done=1 goes to DONE. A bound violation goes to FAIL.
  - DONE=3: traffic continues to be gated normally. Terminal except via FAIL.
  - FAIL=4: sticky; wen=ren=0.
  - A qed_fail assertion moves any non-IDLE state to FAIL.
  - cfg_valid outside IDLE sets cfg_err and is otherwise ignored; depth_q stays constant after the first latch.
- Gating:
  - wen = wen_req & clk_en & (state in RUN/TRACK/DONE) & (wr_cnt < depth_q).
  - ren = ren_req & clk_en & (same states) & (rd_cnt < RD_MULT*depth_q).
  - Reads and writes may be accepted in the same cycle.
- Batch completion:
  - Condition: after this cycle's increments, wr_cnt==depth_q and rd_cnt==RD_MULT*depth_q. This covers both counts completing together or either one completing last.
  - On completion, both counters clear to 0 on the same edge and batch_done pulses for one cycle (registered, visible the next cycle).
  - When a counter is full and its partner is not, further requests on the full side are blocked; the full side holds.
- Post-original tracking:
  - post_rd and post_wr count accepted ren/wen while state is TRACK, including the cycle orig_issued is first seen.
  - Both saturate at all-ones and never wrap.
- Bound check: bound_fail=1 (registered) when state==TRACK, orig_done==0, post_wr>=depth_q and post_rd>=RD_MULT*depth_q+BOUND_SLACK. If orig_done and the bound condition coincide in the same cycle, orig_done wins: no fail, go to DONE.
- QED check: qed_done=1 & qed_check=0 sets qed_fail on the next edge. qed_done is ignored in IDLE.
- Arithmetic: RD_MULT*depth_q is computed at full rd_cnt width with no truncation.

Test Plan:
- Reset, cfg depth=3, continuous wen_req/ren_req, no orig -> 3 writes and 12 reads accepted, batch_done pulses once, counters return to 0, next batch starts.
- depth=2, wen_req held high, ren_req=0 -> exactly 2 wen pulses, then wen=0 until 8 reads complete. Same-cycle final write+read -> single clear, single batch_done.
- depth=3, orig_issued in RUN, orig_done withheld -> bound_fail rises the cycle after post_wr=3 and post_rd=12; state=FAIL; wen=ren=0 thereafter.
- Same as previous, but orig_done arrives the same cycle the 12th read is accepted -> no bound_fail, state=DONE, traffic continues.
- qed_done=1, qed_check=0 in DONE -> qed_fail=1 next cycle, state=FAIL. qed_done=1, qed_check=1 -> no change.
- cfg_depth=0 -> cfg_err=1, stays IDLE, wen=0. Second cfg_valid in RUN -> cfg_err=1, depth_q unchanged. Reset asserted mid-batch -> all outputs 0 immediately.
